// File: rtl/uart_write_d_if.sv
// Byte handshake between the multi-byte UART sender (master) and the
// single-byte transmitter (slave).
interface uart_write_d_if;
  logic       ready;
  logic       send;
  logic [7:0] data;

  modport master (
    input  ready,
    output send,
    output data
  );

  modport slave (
    output ready,
    input  send,
    input  data
  );
endinterface

// File: rtl/uart_write_d.sv
// Single-byte UART transmitter, 8N1 LSB first, ready/send handshake plus a
// bit-rate strobe on tclk. Define UART_WRITED_PARITY_EN for an even-parity bit.
//
// state    | meaning
// ---------+----------------------------------------------------
// S_IDLE   | line high, ready=1, waiting for send
// S_START  | start bit (TX=0)
// S_DATA   | eight data bits, data[0] first
// S_PARITY | even parity of the byte (only with UART_WRITED_PARITY_EN)
// S_STOP   | stop bit (TX=1); ready rises when it ends
module uart_write_d #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic           Clock,
  input  logic           Reset,
  uart_write_d_if.slave  host,
  output logic           TX,
  output logic           tclk
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          tclk_q, tclk_d;
  logic          baud_wrap;
`ifdef UART_WRITED_PARITY_EN
  logic          parity_q, parity_d;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      tclk_q   <= 1'b0;
`ifdef UART_WRITED_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      tclk_q   <= tclk_d;
`ifdef UART_WRITED_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Outputs are computed for the state being entered so every pin is a flop.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
`ifdef UART_WRITED_PARITY_EN
    parity_d  = parity_q;
`endif
    baud_wrap = (baud_q == BAUD_LAST);

    if (state_q != S_IDLE) begin
      baud_d = baud_wrap ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (host.send) begin
          state_d  = S_START;
          shift_d  = host.data;
          baud_d   = '0;
          bit_d    = '0;
          tx_d     = 1'b0;
          ready_d  = 1'b0;
`ifdef UART_WRITED_PARITY_EN
          parity_d = ^host.data;
`endif
        end
      end
      S_START: begin
        if (baud_wrap) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_WRITED_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef UART_WRITED_PARITY_EN
      S_PARITY: begin
        if (baud_wrap) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_wrap) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase

    tclk_d = (state_d != S_IDLE) && (baud_d < BAUD_HALF);
  end

  assign host.ready = ready_q;
  assign TX         = tx_q;
  assign tclk       = tclk_q;

endmodule

// File: tb/tb_uart_write_d.sv
// Randomized bench for uart_write_d: a per-cycle frame timeline model predicts
// ready, TX and tclk; directed frames cover the handshake corner cases.
module tb_uart_write_d;

  localparam int CPB = 4;
`ifdef UART_WRITED_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;
  localparam int LIMIT = 3 * FRAME;

  logic Clock = 1'b0;
  logic Reset;
  logic TX;
  logic tclk;

  uart_write_d_if bus ();

  uart_write_d #(.CLKS_PER_BIT(CPB)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .host  (bus),
    .TX    (TX),
    .tclk  (tclk)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: a frame is a list of line levels, each held CPB cycles.
  bit          m_busy = 1'b0;
  int          m_t    = 0;
  logic [10:0] m_bits = '1;

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    if (NBITS == 11) b[9] = ^d;
    return b;
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      m_busy = 1'b0;
      m_t    = 0;
    end else if (!m_busy) begin
      if (bus.send) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_bits = frame_of(bus.data);
      end
    end else begin
      m_t++;
      if (m_t == FRAME) m_busy = 1'b0;
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("ready", 32'(bus.ready), 32'(!m_busy));
      chk("tx",    32'(TX),        m_busy ? 32'(m_bits[m_t / CPB]) : 32'd1);
      chk("tclk",  32'(tclk),      32'(m_busy && ((m_t % CPB) < (CPB / 2))));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (bus.ready !== 1'b1 && k < LIMIT) begin
      step(1);
      k++;
    end
    if (k == LIMIT) chk("wait_ready", 32'(bus.ready), 32'd1);
  endtask

  // Raise send for `hold` edges and return the number of cycles ready stayed low.
  task automatic pulse_frame(input logic [7:0] d, input int hold, output int n);
    wait_ready();
    bus.send = 1'b1;
    bus.data = d;
    step(1);
    n = 0;
    while (bus.ready === 1'b0 && n < LIMIT) begin
      if (n == hold - 1) bus.send = 1'b0;
      n++;
      step(1);
    end
    bus.send = 1'b0;
    if (n == LIMIT) chk("frame_timeout", 32'(bus.ready), 32'd1);
  endtask

  int n;
  logic [7:0] d;

  initial begin
    Reset    = 1'b1;
    bus.send = 1'b0;
    bus.data = 8'h00;
    step(1);
    chk_en = 1'b1;
    step(2);
    Reset = 1'b0;
    step(6);
    chk("idle_ready", 32'(bus.ready), 32'd1);
    chk("idle_tx",    32'(TX),        32'd1);
    chk("idle_tclk",  32'(tclk),      32'd0);

    pulse_frame(8'h55, 1, n);
    chk("busy_55", 32'(n), 32'(FRAME));
    pulse_frame(8'hA3, 2, n);
    chk("busy_a3", 32'(n), 32'(FRAME));
    step(3);
    chk("no_requeue", 32'(bus.ready), 32'd1);

    wait_ready();
    bus.send = 1'b1;
    bus.data = 8'h00;
    step(3 * (FRAME + 1) + 2);
    bus.send = 1'b0;
    wait_ready();
    step(2);

    bus.send = 1'b1;
    bus.data = 8'hF0;
    step(1);
    bus.send = 1'b0;
    step(CPB * 5 + 1);
    Reset = 1'b1;
    step(1);
    chk("rst_tx",    32'(TX),        32'd1);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    Reset = 1'b0;
    step(1);
    pulse_frame(8'hF0, 1, n);
    chk("busy_f0", 32'(n), 32'(FRAME));

    pulse_frame(8'h07, 1, n);
    chk("busy_07", 32'(n), 32'(FRAME));

    for (int it = 0; it < 40; it++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        wait_ready();
        bus.send = 1'b1;
        bus.data = d;
        step(1);
        bus.send = 1'b0;
        step($urandom_range(1, FRAME - 2));
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
      end else begin
        pulse_frame(d, $urandom_range(1, 3), n);
        chk("busy_rand", 32'(n), 32'(FRAME));
      end
      step($urandom_range(0, 3));
    end

    step(4);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
